// File: rtl/nor3_stim_checker.sv
// Clocked stimulus sequencer and checker for a 3-input NOR gate: sweeps abc 000..111 and counts mismatches.
// Optional NOR3_STIM_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module nor3_stim_checker #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vector_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0] state_reg;
  logic [7:0] hold_cnt_reg;
  logic [2:0] idx_reg;
  logic [3:0] err_reg;
  logic       sample_now;
  logic       mismatch;

  assign sample_now = (hold_cnt_reg == HOLD_LAST);
  // NOR of the driven vector is 1 only for abc = 000
  assign mismatch   = (dut_out != (idx_reg == 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 8'd0;
      idx_reg      <= 3'd0;
      err_reg      <= 4'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= DRIVE;
            hold_cnt_reg <= 8'd0;
            idx_reg      <= 3'd0;
            err_reg      <= 4'd0;
          end
        end
        DRIVE: begin
          if (sample_now) begin
            hold_cnt_reg <= 8'd0;
            if (mismatch) begin
              err_reg <= err_reg + 4'd1;
            end
`ifdef NOR3_STIM_STOP_ON_FAIL_EN
            if (mismatch || idx_reg == 3'd7) begin
              state_reg <= DONE;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
`else
            // index is left at 7 so DONE reports the last vector driven
            if (idx_reg == 3'd7) begin
              state_reg <= DONE;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
`endif
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_reg == DRIVE);
  assign done       = (state_reg == DONE);
  assign pass       = done && (err_reg == 4'd0);
  assign a          = busy & idx_reg[2];
  assign b          = busy & idx_reg[1];
  assign c          = busy & idx_reg[0];
  assign vector_idx = idx_reg;
  assign err_count  = err_reg;

endmodule

// File: tb/tb_nor3_stim_checker.sv
// Directed bench for nor3_stim_checker: H=10 and H=1 instances driven against a selectable NOR model.
module tb_nor3_stim_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start10 = 1'b0;
  logic start1 = 1'b0;
  logic [1:0] mode10 = 2'd0;  // 0: correct NOR, 1: tied 0, 2: tied 1

  logic a10, b10, c10, busy10, done10, pass10, dout10;
  logic [2:0] idx10;
  logic [3:0] err10;
  logic a1, b1, c1, busy1, done1, pass1, dout1;
  logic [2:0] idx1;
  logic [3:0] err1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign dout10 = (mode10 == 2'd0) ? ~(a10 | b10 | c10) : (mode10 == 2'd2);
  assign dout1  = ~(a1 | b1 | c1);

  nor3_stim_checker #(.HOLD_CYCLES(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .dut_out(dout10),
    .a(a10), .b(b10), .c(c10), .vector_idx(idx10),
    .busy(busy10), .done(done10), .pass(pass10), .err_count(err10)
  );

  nor3_stim_checker #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dout1),
    .a(a1), .b(b1), .c(c1), .vector_idx(idx1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // After this returns we are 1ns past edge E0, i.e. inside cycle 1
  task automatic pulse_start10();
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
  endtask

  // Called in cycle 1; walks the full 80-cycle sweep and checks the end state
  task automatic sweep10(input string tag, input logic [3:0] exp_err, input logic exp_pass);
    for (int n = 1; n <= 80; n++) begin
      if ((n - 1) % 10 == 0) check({tag, "_abc"}, {13'd0, a10, b10, c10}, 16'((n - 1) / 10));
      if (n < 80) tick();
    end
    check({tag, "_done_pre"}, {15'd0, done10}, 16'd0);
    tick();
    check({tag, "_done"}, {15'd0, done10}, 16'd1);
    check({tag, "_err"}, {12'd0, err10}, {12'd0, exp_err});
    check({tag, "_pass"}, {15'd0, pass10}, {15'd0, exp_pass});
    check({tag, "_idx"}, {13'd0, idx10}, 16'd7);
  endtask

  initial begin
    // Reset state of both instances
    #2;
    check("reset_out10", {3'd0, a10, b10, c10, idx10, busy10, done10, pass10, err10}, 16'd0);
    check("reset_out1", {3'd0, a1, b1, c1, idx1, busy1, done1, pass1, err1}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_out10", {3'd0, a10, b10, c10, idx10, busy10, done10, pass10, err10}, 16'd0);

    // Correct NOR, H=10
    mode10 = 2'd0;
    pulse_start10();
    check("good_busy", {15'd0, busy10}, 16'd1);
    sweep10("good", 4'd0, 1'b1);

    // Tied 0: only vector 000 mismatches; restart from DONE drops done next cycle
    mode10 = 2'd1;
    pulse_start10();
    check("t0_done_drop", {14'd0, done10, pass10}, 16'd0);
    check("t0_err_clr", {12'd0, err10}, 16'd0);
    sweep10("t0", 4'd1, 1'b0);

    // Tied 1
    mode10 = 2'd2;
    pulse_start10();
`ifdef NOR3_STIM_STOP_ON_FAIL_EN
    for (int n = 1; n < 20; n++) tick();
    check("t1_done_pre", {15'd0, done10}, 16'd0);
    tick();
    check("t1_done", {15'd0, done10}, 16'd1);
    check("t1_idx", {13'd0, idx10}, 16'd1);
    check("t1_err", {12'd0, err10}, 16'd1);
    check("t1_pass", {15'd0, pass10}, 16'd0);
    check("t1_abc", {13'd0, a10, b10, c10}, 16'd0);
`else
    sweep10("t1", 4'd7, 1'b0);
    check("t1_abc_done", {13'd0, a10, b10, c10}, 16'd0);
`endif

    // start re-pulsed during vector 3 is ignored
    mode10 = 2'd0;
    pulse_start10();
    for (int n = 1; n < 80; n++) begin
      if (n == 32) start10 = 1'b1;
      if (n == 35) check("ign_idx", {13'd0, idx10}, 16'd3);
      if (n == 79) check("ign_idx_late", {13'd0, idx10}, 16'd7);
      tick();
      start10 = 1'b0;
    end
    check("ign_done_pre", {15'd0, done10}, 16'd0);
    tick();
    check("ign_done", {14'd0, done10, pass10}, 16'd3);

    // Asynchronous reset in the middle of vector 3
    pulse_start10();
    for (int n = 1; n < 35; n++) tick();
    check("mid_abc", {13'd0, a10, b10, c10}, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {3'd0, a10, b10, c10, idx10, busy10, done10, pass10, err10}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {14'd0, busy10, done10}, 16'd0);
    pulse_start10();
    sweep10("post_rst", 4'd0, 1'b1);

    // H=1, correct DUT
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("h1_busy", {12'd0, busy1, a1, b1, c1}, 16'h8);
    tick();
    check("h1_vec1", {13'd0, a1, b1, c1}, 16'd1);
    for (int n = 2; n < 8; n++) tick();
    check("h1_done_pre", {15'd0, done1}, 16'd0);
    tick();
    check("h1_done", {14'd0, done1, pass1}, 16'd3);
    check("h1_err", {12'd0, err1}, 16'd0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("h1_restart", {13'd0, busy1, done1, pass1}, 16'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
